// File: rtl/lcd_msg_seq.sv
// lcd_msg_seq: byte sequencer ahead of the LCD driver stage.
// Power-up wait, HD44780 8-bit init, then repaints line 1 with the
// ten switch values as '0'/'1' on every switch change.
// Optional: LCD_MSG_SEQ_HEX_EN adds line 2 with three hex digits.
// Ports:
//   clk        slow clock shared with the LCD driver
//   rstBt      async active-low reset
//   switches   raw switches (synchronised here)
//   byte_out   command/character byte (registered)
//   rs_out     0 = command, 1 = character
//   rw_out     tied 0, write only
//   valid      byte_out/rs_out offered to the driver
//   ready      driver accepts; transfer on valid && ready
//   init_done  init sequence finished
//   busy       FSM not in IDLE
module lcd_msg_seq #(
    parameter int PWR_WAIT = 15000,
    parameter int CLR_WAIT = 1600
) (
    input  logic       clk,
    input  logic       rstBt,
    input  logic [9:0] switches,
    output logic [7:0] byte_out,
    output logic       rs_out,
    output logic       rw_out,
    output logic       valid,
    input  logic       ready,
    output logic       init_done,
    output logic       busy
);

    localparam int MAXW = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
    localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;
    localparam logic [CW-1:0] PWR_LAST = CW'(PWR_WAIT - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT - 1);

    typedef enum logic [2:0] {
        PWR, INIT, CLRW, IDLE, ADDR, CHAR
`ifdef LCD_MSG_SEQ_HEX_EN
        , HADDR, HEX
`endif
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [3:0]      idx;
    logic [9:0]      sw_m;
    logic [9:0]      sw_s;
    logic [9:0]      snap;
    logic            force_paint;
    logic            xfer;

    assign rw_out = 1'b0;
    assign xfer   = valid && ready;

    function automatic logic [7:0] bitc(input logic b);
        return b ? 8'h31 : 8'h30;
    endfunction

`ifdef LCD_MSG_SEQ_HEX_EN
    function automatic logic [7:0] hexc(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
    endfunction
`endif

    always_ff @(posedge clk or negedge rstBt) begin
        if (!rstBt) begin
            sw_m <= '0;
            sw_s <= '0;
        end else begin
            sw_m <= switches;
            sw_s <= sw_m;
        end
    end

    always_ff @(posedge clk or negedge rstBt) begin
        if (!rstBt) begin
            state       <= PWR;
            cnt         <= '0;
            idx         <= '0;
            snap        <= '0;
            force_paint <= 1'b1;
            byte_out    <= 8'h00;
            rs_out      <= 1'b0;
            valid       <= 1'b0;
            init_done   <= 1'b0;
            busy        <= 1'b1;
        end else begin
            unique case (state)
                PWR: begin
                    if (cnt == PWR_LAST) begin
                        cnt      <= '0;
                        idx      <= 4'd0;
                        state    <= INIT;
                        byte_out <= 8'h38;
                        rs_out   <= 1'b0;
                        valid    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                INIT: begin
                    if (xfer) begin
                        unique case (idx)
                            4'd0: begin
                                byte_out <= 8'h0C;
                                idx      <= 4'd1;
                            end
                            4'd1: begin
                                byte_out <= 8'h01;
                                idx      <= 4'd2;
                            end
                            4'd2: begin
                                // clear-display needs the long wait
                                valid <= 1'b0;
                                cnt   <= '0;
                                idx   <= 4'd3;
                                state <= CLRW;
                            end
                            default: begin
                                valid     <= 1'b0;
                                init_done <= 1'b1;
                                busy      <= 1'b0;
                                state     <= IDLE;
                            end
                        endcase
                    end
                end
                CLRW: begin
                    if (cnt == CLR_LAST) begin
                        cnt      <= '0;
                        state    <= INIT;
                        byte_out <= 8'h06;
                        rs_out   <= 1'b0;
                        valid    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (force_paint || (sw_s != snap)) begin
                        snap        <= sw_s;
                        force_paint <= 1'b0;
                        state       <= ADDR;
                        byte_out    <= 8'h80;
                        rs_out      <= 1'b0;
                        valid       <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                ADDR: begin
                    if (xfer) begin
                        idx      <= 4'd0;
                        state    <= CHAR;
                        byte_out <= bitc(snap[9]);
                        rs_out   <= 1'b1;
                    end
                end
                CHAR: begin
                    if (xfer) begin
                        if (idx == 4'd9) begin
`ifdef LCD_MSG_SEQ_HEX_EN
                            state    <= HADDR;
                            byte_out <= 8'hC0;
                            rs_out   <= 1'b0;
`else
                            state    <= IDLE;
                            valid    <= 1'b0;
                            busy     <= 1'b0;
`endif
                        end else begin
                            // snap is painted MSB first
                            byte_out <= bitc(snap[4'd8 - idx]);
                            idx      <= idx + 4'd1;
                        end
                    end
                end
`ifdef LCD_MSG_SEQ_HEX_EN
                HADDR: begin
                    if (xfer) begin
                        idx      <= 4'd0;
                        state    <= HEX;
                        byte_out <= hexc({2'b00, snap[9:8]});
                        rs_out   <= 1'b1;
                    end
                end
                HEX: begin
                    if (xfer) begin
                        unique case (idx)
                            4'd0: begin
                                byte_out <= hexc(snap[7:4]);
                                idx      <= 4'd1;
                            end
                            4'd1: begin
                                byte_out <= hexc(snap[3:0]);
                                idx      <= 4'd2;
                            end
                            default: begin
                                state <= IDLE;
                                valid <= 1'b0;
                                busy  <= 1'b0;
                            end
                        endcase
                    end
                end
`endif
                default: begin
                    state <= PWR;
                    cnt   <= '0;
                    valid <= 1'b0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule
